lzw_dict_ctrl: RTL and testbench
================================

Name: lzw_dict_ctrl

Overview:
Dictionary lookup/insert controller for the LZW compressor. It accepts one packed string key, hashes it, and probes an internal hash-indexed dictionary RAM. On a hash collision it queries, and if needed writes to, the downstream 8-entry conflict table. It returns the code for the key (hit), or assigns and returns the next free code (miss/insert).

Parameters:
DATA_WIDTH, 64, key width; matches conflict table data width
HASH_WIDTH, 12, dictionary RAM address width (2^HASH_WIDTH entries)
CODE_WIDTH, 12, LZW code width; must equal HASH_WIDTH (the conflict table stores codes in its hash field)
FIRST_CODE, 256, first assignable code (0-255 are literals)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
in_valid  in  1  key request valid
in_ready  out  1  high only in IDLE
in_key  in  DATA_WIDTH  packed string key; 0 is illegal
res_valid  out  1  one-cycle result pulse
res_hit  out  1  key already present
res_full  out  1  miss that could not be inserted
res_code  out  CODE_WIDTH  found/assigned code; 0 when res_full or illegal key
ct_cs  out  1  conflict table select
ct_we  out  1  conflict table write enable
ct_data  out  DATA_WIDTH  key to conflict table
ct_hash_in  out  HASH_WIDTH  code written into conflict table
ct_match  in  1  combinational match from conflict table
ct_hash_out  in  HASH_WIDTH  stored code, valid the cycle after a read strobe
ct_full  in  1  conflict table full

Behaviour:
- Reset: rst sampled low at posedge -> state CLEAR, clr_addr=0, next_code=FIRST_CODE. All outputs 0 (in_ready=0, res_*=0, ct_cs=0, ct_we=0, ct_data=0, ct_hash_in=0). Reset mid-operation aborts immediately; no pending RAM/CT write completes.
- CLEAR: writes valid=0 to RAM[clr_addr] once per cycle. Lasts 2^HASH_WIDTH cycles (4096 at default), then IDLE.
- Hash: XOR-fold of key in HASH_WIDTH chunks, LSB first, zero-padded last chunk.
- RAM: single port, synchronous read (1 cycle); entry = {valid, key, code}.
- Transaction, handshake at cycle T:
  - T+1 RD: RAM read at hash.
  - T+2 CMP:
    - valid & key equal -> DONE, hit.
    - !valid -> write {1, key, next_code}; DONE, miss.
    - valid & mismatch -> CT_Q.
  - CT_Q: ct_cs=1, ct_we=0, ct_data=key.
    - ct_match -> CT_RD.
    - else !ct_full -> CT_WR.
    - else DONE with res_full.
  - CT_RD: hold ct_cs=1, ct_we=0; capture ct_hash_out -> DONE, hit.
  - CT_WR: ct_cs=1, ct_we=1, ct_hash_in=next_code -> DONE, miss.
  - DONE: res_valid=1 for one cycle -> IDLE.
- Latencies: RAM hit/insert res_valid at T+3; CT hit/insert at T+5; CT-full at T+4.
- Code exhaustion: if next_code == 2^CODE_WIDTH-1, any insert becomes res_full; no RAM/CT write.
- next_code increments only on a successful insert.
- Illegal key 0: from IDLE directly to DONE (T+1) with res_hit=0, res_full=0, res_code=0; no RAM/CT access.
- ct_cs is 0 in every state except CT_Q/CT_RD/CT_WR.
- in_valid is ignored outside IDLE.

Optional Feature:
LZW_DICT_STATS_EN
- Defined: adds outputs stat_hits, stat_ct_hits, stat_inserts, stat_full, each 32 bits. Each increments at DONE per result type, saturates at all-ones, and clears on reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package lzw_pkg:
  - state enum (CLEAR, IDLE, RD, CMP, CT_Q, CT_RD, CT_WR, DONE)
  - FIRST_CODE constant
  - hash_fold function
  - dictionary entry struct typedef
- Sub-module lzw_hash_ram: single-port sync-read RAM holding the entries; controller owns all FSM logic.

Test Plan:
- Reset release -> in_ready=0 for exactly 4096 cycles, then 1; all res_*/ct_* outputs 0 throughout.
- Key 0x41 -> miss, res_code=256 at T+3; key 0x41 again -> res_hit=1, res_code=256 at T+3.
- Key 0x40 (code 256), then 0x1041 (same hash 0x040) -> CT_WR with ct_hash_in=257, miss code 257 at T+5. Repeat 0x1041 -> ct_cs high two cycles, hit code 257 at T+5.
- Collision with model ct_full=1, ct_match=0 -> res_full=1, res_code=0 at T+4. Next fresh key still gets the unconsumed next code.
- Insert 3839 distinct non-colliding keys (codes 256-4094). Next new key -> res_full=1 and no RAM write (re-lookup misses again).
- rst low during CT_RD -> next cycle ct_cs=0, in_ready=0, CLEAR restarts. in_key=0 -> res_valid at T+1 with res_code=0, no ct_cs.

Source files
------------

// File: rtl/lzw_pkg.sv
// Shared types and helpers for the LZW dictionary controller: FSM states,
// the dictionary entry layout and the key-to-address hash.
package lzw_pkg;

    localparam int LZW_DATA_W     = 64;
    localparam int LZW_HASH_W     = 12;
    localparam int LZW_FIRST_CODE = 256;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_RD,
        ST_CMP,
        ST_CT_Q,
        ST_CT_RD,
        ST_CT_WR,
        ST_DONE
    } state_t;

    // Code field shares the hash width: the conflict table stores codes in its hash slot
    typedef struct packed {
        logic                  valid;
        logic [LZW_DATA_W-1:0] key;
        logic [LZW_HASH_W-1:0] code;
    } dict_entry_t;

    // XOR-fold of the key in hash-width chunks, LSB first; the right shift zero-pads the last chunk
    function automatic logic [LZW_HASH_W-1:0] hash_fold(input logic [LZW_DATA_W-1:0] key);
        logic [LZW_HASH_W-1:0] h;
        h = '0;
        for (int c = 0; c < (LZW_DATA_W + LZW_HASH_W - 1) / LZW_HASH_W; c++) begin
            h = h ^ LZW_HASH_W'(key >> (c * LZW_HASH_W));
        end
        return h;
    endfunction

endpackage

// File: rtl/lzw_hash_ram.sv
// Single-port dictionary RAM with one-cycle synchronous read.
module lzw_hash_ram #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 77
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_we,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    // Write port and registered read port share the single address
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/lzw_dict_ctrl.sv
// LZW dictionary lookup/insert controller with conflict-table overflow.
// Optional result counters are built when LZW_DICT_STATS_EN is defined.
module lzw_dict_ctrl
    import lzw_pkg::*;
#(
    parameter int DATA_WIDTH = LZW_DATA_W,
    parameter int HASH_WIDTH = LZW_HASH_W,
    parameter int CODE_WIDTH = LZW_HASH_W,
    parameter int FIRST_CODE = LZW_FIRST_CODE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_key,
    output logic                  res_valid,
    output logic                  res_hit,
    output logic                  res_full,
    output logic [CODE_WIDTH-1:0] res_code,
    output logic                  ct_cs,
    output logic                  ct_we,
    output logic [DATA_WIDTH-1:0] ct_data,
    output logic [HASH_WIDTH-1:0] ct_hash_in,
    input  logic                  ct_match,
    input  logic [HASH_WIDTH-1:0] ct_hash_out,
    input  logic                  ct_full
`ifdef LZW_DICT_STATS_EN
    ,
    output logic [31:0]           stat_hits,
    output logic [31:0]           stat_ct_hits,
    output logic [31:0]           stat_inserts,
    output logic [31:0]           stat_full
`endif
);

    state_t                r_state, w_state_n;
    logic [HASH_WIDTH-1:0] r_clr_addr;
    logic [CODE_WIDTH-1:0] r_next_code;
    logic [DATA_WIDTH-1:0] r_key;
    logic [HASH_WIDTH-1:0] w_hash;
    logic                  w_exhausted;
    logic                  w_ram_ins, w_ram_we, w_code_inc;
    logic [HASH_WIDTH-1:0] w_ram_addr;
    dict_entry_t           w_rd_entry, w_wr_entry;
    logic [$bits(dict_entry_t)-1:0] w_ram_rdata;

    logic                  r_in_ready, r_res_valid, r_res_hit, r_res_full, r_ct_cs, r_ct_we;
    logic [CODE_WIDTH-1:0] r_res_code;
    logic [DATA_WIDTH-1:0] r_ct_data;
    logic [HASH_WIDTH-1:0] r_ct_hash_in;
    logic                  w_res_hit_n, w_res_full_n, w_ct_cs_n, w_ct_we_n;
    logic [CODE_WIDTH-1:0] w_res_code_n;

    assign w_hash      = hash_fold(r_key);
    assign w_exhausted = (r_next_code == {CODE_WIDTH{1'b1}});
    assign w_rd_entry  = dict_entry_t'(w_ram_rdata);
    assign w_ram_addr  = (r_state == ST_CLEAR) ? r_clr_addr : w_hash;
    assign w_ram_we    = rst & ((r_state == ST_CLEAR) | w_ram_ins);

    // Clearing writes an all-zero (invalid) entry; inserts write the new key/code
    always_comb begin
        w_wr_entry = '0;
        if (r_state != ST_CLEAR) begin
            w_wr_entry.valid = 1'b1;
            w_wr_entry.key   = r_key;
            w_wr_entry.code  = r_next_code;
        end else begin
            w_wr_entry = '0;
        end
    end

    lzw_hash_ram #(
        .ADDR_W (HASH_WIDTH),
        .DATA_W ($bits(dict_entry_t))
    ) u_ram (
        .clk     (clk),
        .i_addr  (w_ram_addr),
        .i_we    (w_ram_we),
        .i_wdata (w_wr_entry),
        .o_rdata (w_ram_rdata)
    );

    // Next-state and result decode
    always_comb begin
        w_state_n    = r_state;
        w_res_hit_n  = 1'b0;
        w_res_full_n = 1'b0;
        w_res_code_n = '0;
        w_code_inc   = 1'b0;
        w_ram_ins    = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                if (r_clr_addr == {HASH_WIDTH{1'b1}}) w_state_n = ST_IDLE;
                else                                   w_state_n = ST_CLEAR;
            end
            ST_IDLE: begin
                if (in_valid) begin
                    if (in_key == '0) w_state_n = ST_DONE;
                    else              w_state_n = ST_RD;
                end else begin
                    w_state_n = ST_IDLE;
                end
            end
            ST_RD: w_state_n = ST_CMP;
            ST_CMP: begin
                if (w_rd_entry.valid && (w_rd_entry.key == r_key)) begin
                    w_state_n    = ST_DONE;
                    w_res_hit_n  = 1'b1;
                    w_res_code_n = w_rd_entry.code;
                end else if (!w_rd_entry.valid) begin
                    w_state_n = ST_DONE;
                    if (w_exhausted) begin
                        w_res_full_n = 1'b1;
                    end else begin
                        w_ram_ins    = 1'b1;
                        w_code_inc   = 1'b1;
                        w_res_code_n = r_next_code;
                    end
                end else begin
                    w_state_n = ST_CT_Q;
                end
            end
            ST_CT_Q: begin
                if (ct_match)                      w_state_n = ST_CT_RD;
                else if (!ct_full && !w_exhausted) w_state_n = ST_CT_WR;
                else begin
                    w_state_n    = ST_DONE;
                    w_res_full_n = 1'b1;
                end
            end
            ST_CT_RD: begin
                w_state_n    = ST_DONE;
                w_res_hit_n  = 1'b1;
                w_res_code_n = ct_hash_out;
            end
            ST_CT_WR: begin
                w_state_n    = ST_DONE;
                w_code_inc   = 1'b1;
                w_res_code_n = r_next_code;
            end
            ST_DONE: w_state_n = ST_IDLE;
            default: w_state_n = ST_CLEAR;
        endcase
    end

    assign w_ct_cs_n = (w_state_n == ST_CT_Q) || (w_state_n == ST_CT_RD) || (w_state_n == ST_CT_WR);
    assign w_ct_we_n = (w_state_n == ST_CT_WR);

    // State, bookkeeping and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_CLEAR;
            r_clr_addr   <= '0;
            r_next_code  <= CODE_WIDTH'(FIRST_CODE);
            r_key        <= '0;
            r_in_ready   <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_hit    <= 1'b0;
            r_res_full   <= 1'b0;
            r_res_code   <= '0;
            r_ct_cs      <= 1'b0;
            r_ct_we      <= 1'b0;
            r_ct_data    <= '0;
            r_ct_hash_in <= '0;
        end else begin
            r_state <= w_state_n;
            if (r_state == ST_CLEAR)              r_clr_addr  <= r_clr_addr + 1'b1;
            if ((r_state == ST_IDLE) && in_valid) r_key       <= in_key;
            if (w_code_inc)                       r_next_code <= r_next_code + 1'b1;
            r_in_ready   <= (w_state_n == ST_IDLE);
            r_res_valid  <= (w_state_n == ST_DONE);
            r_res_hit    <= w_res_hit_n;
            r_res_full   <= w_res_full_n;
            r_res_code   <= w_res_code_n;
            r_ct_cs      <= w_ct_cs_n;
            r_ct_we      <= w_ct_we_n;
            r_ct_data    <= w_ct_cs_n ? r_key : '0;
            r_ct_hash_in <= w_ct_we_n ? r_next_code : '0;
        end
    end

    assign in_ready   = r_in_ready;
    assign res_valid  = r_res_valid;
    assign res_hit    = r_res_hit;
    assign res_full   = r_res_full;
    assign res_code   = r_res_code;
    assign ct_cs      = r_ct_cs;
    assign ct_we      = r_ct_we;
    assign ct_data    = r_ct_data;
    assign ct_hash_in = r_ct_hash_in;

`ifdef LZW_DICT_STATS_EN
    logic [31:0] r_stat_hits, r_stat_ct_hits, r_stat_inserts, r_stat_full;
    logic        r_from_ct;

    // Saturating result counters, classified while the result is on the outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stat_hits    <= '0;
            r_stat_ct_hits <= '0;
            r_stat_inserts <= '0;
            r_stat_full    <= '0;
            r_from_ct      <= 1'b0;
        end else begin
            r_from_ct <= (r_state == ST_CT_RD);
            if (r_state == ST_DONE) begin
                if (r_res_hit && !r_from_ct && (r_stat_hits != '1))    r_stat_hits    <= r_stat_hits + 1'b1;
                if (r_res_hit && r_from_ct && (r_stat_ct_hits != '1))  r_stat_ct_hits <= r_stat_ct_hits + 1'b1;
                if (r_res_full && (r_stat_full != '1))                 r_stat_full    <= r_stat_full + 1'b1;
                if (!r_res_hit && !r_res_full && (r_res_code != '0) && (r_stat_inserts != '1))
                    r_stat_inserts <= r_stat_inserts + 1'b1;
            end
        end
    end

    assign stat_hits    = r_stat_hits;
    assign stat_ct_hits = r_stat_ct_hits;
    assign stat_inserts = r_stat_inserts;
    assign stat_full    = r_stat_full;
`endif

endmodule

// File: tb/tb_lzw_dict_ctrl.sv
// Directed bench for lzw_dict_ctrl with a behavioural 8-entry conflict table.
module tb_lzw_dict_ctrl;

    logic        clk, rst, in_valid, in_ready;
    logic [63:0] in_key;
    logic        res_valid, res_hit, res_full;
    logic [11:0] res_code;
    logic        ct_cs, ct_we, ct_match, ct_full;
    logic [63:0] ct_data;
    logic [11:0] ct_hash_in, ct_hash_out;

    int n_total = 0;
    int n_bad   = 0;

    lzw_dict_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key),
        .res_valid(res_valid), .res_hit(res_hit), .res_full(res_full), .res_code(res_code),
        .ct_cs(ct_cs), .ct_we(ct_we), .ct_data(ct_data), .ct_hash_in(ct_hash_in),
        .ct_match(ct_match), .ct_hash_out(ct_hash_out), .ct_full(ct_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Conflict table model
    logic [63:0] ct_keys  [8];
    logic [11:0] ct_codes [8];
    int          ct_cnt = 0;
    logic        force_full = 1'b0;
    logic [11:0] ct_mcode;

    always_comb begin
        ct_match = 1'b0;
        ct_mcode = 12'h000;
        for (int i = 0; i < 8; i++) begin
            if (i < ct_cnt && ct_cs && !ct_we && ct_keys[i] == ct_data) begin
                ct_match = 1'b1;
                ct_mcode = ct_codes[i];
            end
        end
    end
    assign ct_full = force_full || (ct_cnt == 8);

    always @(posedge clk) begin
        if (ct_cs && ct_we && ct_cnt < 8) begin
            ct_keys[ct_cnt]  <= ct_data;
            ct_codes[ct_cnt] <= ct_hash_in;
            ct_cnt           <= ct_cnt + 1;
        end
        if (ct_cs && !ct_we) ct_hash_out <= ct_mcode;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [63:0] key;
        logic        ffull;
        logic        hit;
        logic        full;
        logic [11:0] code;
        int          lat;
        int          cs_n;
        logic [11:0] wcode;
    } vec_t;

    // One request: returns cycles from handshake to result, ct activity seen and pulse width check
    task automatic do_req(input logic [63:0] key, output int lat, output logic hit, output logic full,
                          output logic [11:0] code, output int cs_n, output logic [11:0] wcode,
                          output logic pulse_ok);
        bit got;
        int w;
        got = 0; cs_n = 0; wcode = 12'h000; hit = 1'b0; full = 1'b0; code = 12'h000;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        in_valid = 1'b1;
        in_key   = key;
        @(posedge clk);
        lat = 0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            in_valid = 1'b0;
            if (ct_cs && ct_data == key) cs_n++;
            if (ct_cs && ct_we) wcode = ct_hash_in;
            if (res_valid) begin
                got = 1; hit = res_hit; full = res_full; code = res_code;
            end
        end
        if (!got) lat = -1;
        @(negedge clk);
        pulse_ok = !res_valid;
    endtask

    task automatic run_vec(input vec_t t, input string tag);
        int lat, cs_n;
        logic hit, full, pulse_ok;
        logic [11:0] code, wcode;
        force_full = t.ffull;
        do_req(t.key, lat, hit, full, code, cs_n, wcode, pulse_ok);
        force_full = 1'b0;
        chk({tag, "_lat"},   64'(lat), 64'(t.lat));
        chk({tag, "_hit"},   64'(hit), 64'(t.hit));
        chk({tag, "_full"},  64'(full), 64'(t.full));
        chk({tag, "_code"},  64'(code), 64'(t.code));
        chk({tag, "_cs"},    64'(cs_n), 64'(t.cs_n));
        chk({tag, "_ctw"},   64'(wcode), 64'(t.wcode));
        chk({tag, "_pulse"}, 64'(pulse_ok), 64'd1);
    endtask

    // Counts edges after reset release until in_ready, watching that everything else stays quiet
    task automatic clear_check(input string tag);
        int cnt;
        logic noisy;
        cnt = 0; noisy = 1'b0;
        while (cnt < 5000) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (res_valid || res_hit || res_full || res_code != 12'h000 || ct_cs || ct_we ||
                ct_data != 64'h0 || ct_hash_in != 12'h000) noisy = 1'b1;
            if (in_ready) break;
        end
        chk({tag, "_len"}, 64'(cnt), 64'd4096);
        chk({tag, "_quiet"}, 64'(noisy), 64'd0);
    endtask

    vec_t vt [10];

    initial begin
        vec_t t;
        int w;
        vt[0] = '{64'h40,   1'b0, 1'b0, 1'b0, 12'd256, 3, 0, 12'd0};
        vt[1] = '{64'h1041, 1'b0, 1'b0, 1'b0, 12'd257, 5, 2, 12'd257};
        vt[2] = '{64'h1041, 1'b0, 1'b1, 1'b0, 12'd257, 5, 2, 12'd0};
        vt[3] = '{64'h41,   1'b0, 1'b0, 1'b0, 12'd258, 3, 0, 12'd0};
        vt[4] = '{64'h41,   1'b0, 1'b1, 1'b0, 12'd258, 3, 0, 12'd0};
        vt[5] = '{64'h2042, 1'b1, 1'b0, 1'b1, 12'd0,   4, 1, 12'd0};
        vt[6] = '{64'h55,   1'b0, 1'b0, 1'b0, 12'd259, 3, 0, 12'd0};
        vt[7] = '{64'h0,    1'b0, 1'b0, 1'b0, 12'd0,   1, 0, 12'd0};
        vt[8] = '{64'h55,   1'b0, 1'b1, 1'b0, 12'd259, 3, 0, 12'd0};
        vt[9] = '{64'h40,   1'b0, 1'b1, 1'b0, 12'd256, 3, 0, 12'd0};

        rst = 1'b0; in_valid = 1'b0; in_key = 64'h0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_outs", 64'({res_valid, res_hit, res_full, ct_cs, ct_we}), 64'd0);
        rst = 1'b1;
        clear_check("clear1");

        for (int i = 0; i < 10; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // Reset while the conflict table read is in progress
        @(negedge clk);
        in_valid = 1'b1; in_key = 64'h1041;
        @(posedge clk);
        w = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            w++;
        end while (!ct_cs && w < 10);
        @(negedge clk);
        chk("ctrd_cs", 64'({ct_cs, ct_we}), 64'b10);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_cs", 64'(ct_cs), 64'd0);
        chk("abort_ready", 64'(in_ready), 64'd0);
        chk("abort_res", 64'(res_valid), 64'd0);
        rst = 1'b1;
        clear_check("clear2");
        run_vec('{64'h40, 1'b0, 1'b0, 1'b0, 12'd256, 3, 0, 12'd0}, "post_rst");

        // Fill the remaining codes 257..4094 with keys whose hash equals the key
        for (int i = 0; i < 3838; i++) begin
            t = '{64'(32'h100 + i), 1'b0, 1'b0, 1'b0, 12'(257 + i), 3, 0, 12'd0};
            run_vec(t, $sformatf("fill%0d", i));
        end
        run_vec('{64'hFFE,  1'b0, 1'b0, 1'b1, 12'd0,   3, 0, 12'd0}, "exh_new");
        run_vec('{64'hFFE,  1'b0, 1'b0, 1'b1, 12'd0,   3, 0, 12'd0}, "exh_again");
        run_vec('{64'h1140, 1'b0, 1'b0, 1'b1, 12'd0,   4, 1, 12'd0}, "exh_ct");
        run_vec('{64'h100,  1'b0, 1'b1, 1'b0, 12'd257, 3, 0, 12'd0}, "exh_hit");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
